// File: rtl/onchip_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_pipelined
// Description : Avalon-MM single-port on-chip RAM slave with a pipelined read
//               path (readdatavalid, latency 1 or 2), waitrequest flow control
//               (freeze, clock enable, clear engine) and out-of-range handling
//               for depths that are not a power of two.
// Optional    : ONCHIP_MEM_CLEAR_ON_RESET_EN - when defined, a clear engine
//               zeroes every word after reset and holds waitrequest meanwhile.
//               When undefined, contents survive reset.
// Ports       : clk, reset_n (sync, active-low)
//               address/byteenable/chipselect/read/write/writedata - Avalon-MM
//               clken  - 0 stalls every pipeline stage
//               freeze - blocks acceptance of new requests only
//               readdata/readdatavalid - registered read return
//               waitrequest - request not accepted this cycle
//               oob_err - sticky out-of-range access flag, cleared by reset
// Parameters  : DATA_W, DEPTH, ADDR_W, READ_LATENCY (1 or 2), INIT_FILE
//               (power-up image name kept for instance compatibility; content
//               is attached by the device-programming flow).
// Revision    : 1.0 - initial pipelined release
// ============================================================================
module onchip_mem_pipelined #(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 6144,
    parameter int    ADDR_W       = 13,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_mem_pipelined.hex"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    input  logic                  freeze,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  oob_err
);

    localparam int               c_NBYTES = DATA_W / 8;
    localparam int               c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH  = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_clear_busy;
    logic               w_clr_we;
    logic [c_IDX_W-1:0] w_clr_idx;

    logic               w_in_range;
    logic               w_accept;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_rd_word;

    logic               r_rdv;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_oob;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    assign waitrequest = reset_n & (freeze | ~clken | w_clear_busy);
    assign w_accept    = chipselect & (read | write) & ~waitrequest & reset_n;
    // A combined read+write performs only the write.
    assign w_wr_acc    = w_accept & write;
    assign w_rd_acc    = w_accept & read & ~write;

    assign w_in_range  = ({1'b0, address} < c_DEPTH);
    assign w_idx       = address[c_IDX_W-1:0];
    assign w_rd_word   = w_in_range ? r_mem[w_idx] : '0;

    // ------------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------------
`ifdef ONCHIP_MEM_CLEAR_ON_RESET_EN
    localparam logic [1:0]         c_ST_IDLE  = 2'd0;
    localparam logic [1:0]         c_ST_CLEAR = 2'd1;
    localparam logic [1:0]         c_ST_READY = 2'd2;
    localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(DEPTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_clr_cnt;
    logic [c_IDX_W-1:0] w_clr_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= c_ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_state_nxt   = c_ST_CLEAR;
                w_clr_cnt_nxt = '0;
            end
            c_ST_CLEAR: begin
                if (clken && reset_n) begin
                    w_clr_we = 1'b1;
                    if (r_clr_cnt == c_LAST) begin
                        w_state_nxt = c_ST_READY;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                    end
                end
            end
            c_ST_READY: begin
                w_state_nxt = c_ST_READY;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_clear_busy = (r_state != c_ST_READY);
    assign w_clr_idx    = r_clr_cnt;
`else
    assign w_clear_busy = 1'b0;
    assign w_clr_we     = 1'b0;
    assign w_clr_idx    = '0;
`endif

    // ------------------------------------------------------------------------
    // Storage: the clear engine and bus writes are mutually exclusive because
    // the bus is held off with waitrequest while clearing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_acc && w_in_range) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (byteenable[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline: every stage advances only on clken; readdata reloads only
    // when a valid word moves into the output stage.
    // ------------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_v1;
            logic [DATA_W-1:0] r_d1;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_v1    <= 1'b0;
                    r_d1    <= '0;
                    r_rdv   <= 1'b0;
                    r_rdata <= '0;
                end else if (clken) begin
                    r_v1  <= w_rd_acc;
                    r_rdv <= r_v1;
                    if (w_rd_acc) begin
                        r_d1 <= w_rd_word;
                    end
                    if (r_v1) begin
                        r_rdata <= r_d1;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_rdv   <= 1'b0;
                    r_rdata <= '0;
                end else if (clken) begin
                    r_rdv <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    // A pending return is masked (not lost) during a stall and dropped by reset.
    assign readdatavalid = r_rdv & clken & reset_n;
    assign readdata      = r_rdata;

    // ------------------------------------------------------------------------
    // Sticky out-of-range flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_oob <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_oob <= 1'b1;
        end
    end

    assign oob_err = r_oob;

endmodule
`default_nettype wire

// File: doc/onchip_mem_pipelined.md
Name: onchip_mem_pipelined

Overview:
- Parametrised Avalon-MM on-chip RAM slave; next generation of the single-port data-memory block in the Qsys system.
- Adds a pipelined read path with readdatavalid and a selectable read latency of 1 or 2.
- Adds waitrequest-based flow control for freeze, clock-enable and an internal clear engine.
- Adds out-of-range address handling for non-power-of-two depths.
- Sits between the Qsys interconnect and the processor data path; replaces fixed-latency single-port instances.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 6144, number of words; need not be a power of two.
- ADDR_W, 13, word-address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- INIT_FILE, "onchip_mem_pipelined.hex", memory init image; ignored when the clear engine is compiled in.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  byte-lane write enables.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- clken  in  1  clock enable; 0 stalls the block.
- freeze  in  1  blocks acceptance of new requests.
- readdata  out  DATA_W  read data; valid when readdatavalid=1.
- readdatavalid  out  1  single-cycle read-return strobe.
- waitrequest  out  1  request not accepted this cycle.
- oob_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (reset_n=0 at a rising clk edge):
  - readdata=0, readdatavalid=0, oob_err=0; read pipeline flushed.
  - Reads in flight are dropped; no readdatavalid is ever issued for them.
  - Memory contents are preserved (unless the optional feature is compiled in).
- waitrequest = freeze | ~clken | clear_busy. Combinational; 0 during reset (clear_busy is 0 when the feature is absent).
- Accept rule: chipselect & (read|write) & ~waitrequest & reset_n.
  - Master holds its request while waitrequest=1.
  - Unselected cycles are ignored.
- Write:
  - Each byte lane i with byteenable[i]=1 is updated at the accepting edge; other lanes unchanged.
  - byteenable=0 is accepted as a no-op.
- Simultaneous read and write: write performed, read discarded, no readdatavalid.
- Read:
  - readdatavalid pulses exactly READ_LATENCY clken-active cycles after acceptance.
  - readdata carries the word; both are registered outputs.
  - Pipelined: one read accepted per cycle, so N back-to-back reads give N consecutive valid cycles in order.
- Read-after-write: a write accepted at cycle N followed by a read of the same address at N+1 returns the new data.
- clken=0:
  - All pipeline stages hold their state.
  - readdatavalid forced 0 while clken=0; a pending return is issued after clken returns high.
  - readdata holds its last value.
- freeze=1: blocks new acceptance only; reads already in flight complete normally.
- Out of range (address >= DEPTH):
  - Writes are dropped.
  - Reads return 0 with normal readdatavalid timing.
  - oob_err is set to 1 and cleared only by reset.
- Address wrap: none. Address DEPTH-1 is the last valid word.

Optional Feature:
- Macro: ONCHIP_MEM_CLEAR_ON_RESET_EN.
- Defined: adds an FSM with states IDLE, CLEAR, READY.
  - Reset enters CLEAR with counter=0 and clear_busy=1, so waitrequest=1.
  - CLEAR writes 0 to word[counter] each clken-active cycle, then increments the counter.
  - At counter=DEPTH-1 the FSM writes that word and moves to READY; clear_busy=0 from the next cycle.
  - Clear time is DEPTH clken-active cycles.
  - Reset asserted mid-clear restarts the clear at word 0.
  - INIT_FILE is ignored.
- Undefined: the FSM is absent and clear_busy is tied to 0. The memory initialises from INIT_FILE and contents survive reset.

Test Plan:
- Reset, then write 0xDEADBEEF to address 5 with byteenable=4'hF, then write 0x000000AA to address 5 with byteenable=4'b0001, then read address 5 -> readdata=0xDEADBEAA, readdatavalid exactly READ_LATENCY cycles after acceptance.
- READ_LATENCY=2, reads to addresses 0..3 on consecutive cycles (preloaded 0x10..0x13) -> four consecutive readdatavalid cycles returning 0x10, 0x11, 0x12, 0x13 in order.
- freeze=1 for 3 cycles while the master holds read of address 7 -> waitrequest=1 for those 3 cycles; read accepted on the first cycle with freeze=0; a read already in flight still returns during the freeze.
- Read address 6144 and write address 6200 (DEPTH=6144) -> read returns 0 with readdatavalid; word 6144 mod 8192 is untouched; oob_err=1 and stays 1 until reset_n=0.
- Read accepted, then clken=0 for 2 cycles -> no readdatavalid during the stall; readdatavalid asserted after clken=1 with the correct data. A second read with reset_n=0 asserted the cycle after acceptance -> no readdatavalid, readdata=0.
- With ONCHIP_MEM_CLEAR_ON_RESET_EN and DEPTH=16: release reset -> waitrequest=1 for exactly 16 cycles; then reads of addresses 0..15 all return 0. Reset at clear cycle 8 -> 16 further busy cycles.
